// File: rtl/ldiv_arbiter.sv
// rtl/ldiv_arbiter.sv - round-robin front end sharing one pipelined long divider
// A tag pipe follows each issued op through the divider and steers the result back.
module ldiv_arbiter #(
   parameter int NUM_REQ           = 4,
   parameter int NUMERATOR_WIDTH   = 10,
   parameter int DENOMINATOR_WIDTH = 10,
   parameter int QUOTIENT_WIDTH    = 10,
   parameter int DIV_LATENCY       = NUMERATOR_WIDTH + 1,
   parameter int MAX_OUTSTANDING   = 4
) (
   input  logic                                 clk,
   input  logic                                 resetb,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ*NUMERATOR_WIDTH-1:0]   req_numerator,
   input  logic [NUM_REQ*DENOMINATOR_WIDTH-1:0] req_denominator,
   output logic [NUMERATOR_WIDTH-1:0]           div_numerator,
   output logic [DENOMINATOR_WIDTH-1:0]         div_denominator,
   output logic                                 div_valid,
   input  logic [QUOTIENT_WIDTH-1:0]            div_quotient,
   input  logic [NUMERATOR_WIDTH-1:0]           div_remainder,
   input  logic                                 div_valid_out,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [QUOTIENT_WIDTH-1:0]            rsp_quotient,
   output logic [NUMERATOR_WIDTH-1:0]           rsp_remainder,
   output logic                                 rsp_div_by_zero,
   output logic                                 busy,
   output logic                                 seq_error
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int NW = NUMERATOR_WIDTH;
   localparam int DW = DENOMINATOR_WIDTH;
   localparam int L  = DIV_LATENCY;

   logic [IW-1:0]      ptr;
   logic [CW-1:0]      outstanding [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;
   logic               grant_found;
   logic [IW-1:0]      grant_id;
   int                 scan_idx;
   logic [DW-1:0]      grant_den;

   logic [IW-1:0]      issue_id;
   logic               issue_dbz;
   logic [L-1:0]       tag_valid;
   logic [L-1:0]       tag_dbz;
   logic [IW-1:0]      tag_id [L];
   logic               head_valid;
   logic               rsp_fire;

   // A response leaving this cycle frees its slot, so a full requester may re-issue at once.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_valid[i] & ((outstanding[i] < CW'(MAX_OUTSTANDING)) | rsp_valid[i]);
   end

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = 0;
      req_ready   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_found && eligible[scan_idx]) begin
            grant_found = 1'b1;
            grant_id    = scan_idx[IW-1:0];
         end
      end
      if (grant_found)
         req_ready[grant_id] = 1'b1;
   end

   assign grant_den = req_denominator[grant_id*DW +: DW];

   always_ff @(posedge clk) begin
      if (!resetb) begin
         ptr             <= IW'(NUM_REQ - 1);
         div_valid       <= 1'b0;
         div_numerator   <= '0;
         div_denominator <= '0;
         issue_id        <= '0;
         issue_dbz       <= 1'b0;
      end else begin
         div_valid <= grant_found;
         if (grant_found) begin
            ptr             <= grant_id;
            div_numerator   <= req_numerator[grant_id*NW +: NW];
            div_denominator <= grant_den;
            issue_id        <= grant_id;
            issue_dbz       <= (grant_den == '0);
         end
      end
   end

   // The issue register is the first stage, so the head lines up with div_valid_out.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         tag_valid <= '0;
         tag_dbz   <= '0;
         for (int s = 0; s < L; s++)
            tag_id[s] <= '0;
      end else begin
         tag_valid[0] <= div_valid;
         tag_dbz[0]   <= issue_dbz;
         tag_id[0]    <= issue_id;
         for (int s = 1; s < L; s++) begin
            tag_valid[s] <= tag_valid[s-1];
            tag_dbz[s]   <= tag_dbz[s-1];
            tag_id[s]    <= tag_id[s-1];
         end
      end
   end

   assign head_valid = tag_valid[L-1];
   assign rsp_fire   = head_valid & div_valid_out;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         rsp_valid       <= '0;
         rsp_quotient    <= '0;
         rsp_remainder   <= '0;
         rsp_div_by_zero <= 1'b0;
         seq_error       <= 1'b0;
      end else begin
         rsp_valid       <= '0;
         rsp_div_by_zero <= rsp_fire & tag_dbz[L-1];
         if (rsp_fire) begin
            rsp_valid[tag_id[L-1]] <= 1'b1;
            rsp_quotient           <= div_quotient;
            rsp_remainder          <= div_remainder;
         end
         if (div_valid_out != head_valid)
            seq_error <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!resetb)
            outstanding[i] <= '0;
         else if (req_ready[i] && req_valid[i] && !rsp_valid[i])
            outstanding[i] <= outstanding[i] + CW'(1);
         else if (!(req_ready[i] && req_valid[i]) && rsp_valid[i])
            outstanding[i] <= outstanding[i] - CW'(1);
      end
   end

   assign busy = div_valid | (|tag_valid) | (|rsp_valid);

endmodule

// File: tb/tb_ldiv_arbiter.sv
// tb/tb_ldiv_arbiter.sv - self-checking bench for ldiv_arbiter with a behavioural divider
module tb_ldiv_arbiter;
   localparam int NR   = 4;
   localparam int W    = 10;
   localparam int LAT  = W + 1;
   localparam int MAXO = 2;
   localparam int RSP_LAT = LAT + 2;

   logic              clk = 1'b0;
   logic              resetb = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*W-1:0]   req_numerator;
   logic [NR*W-1:0]   req_denominator;
   logic [W-1:0]      div_numerator, div_denominator;
   logic              div_valid;
   logic [W-1:0]      div_quotient, div_remainder;
   logic              div_valid_out;
   logic [NR-1:0]     rsp_valid;
   logic [W-1:0]      rsp_quotient, rsp_remainder;
   logic              rsp_div_by_zero, busy, seq_error;
   logic              force_vo = 1'b0;
   logic [W-1:0]      num_a [NR];
   logic [W-1:0]      den_a [NR];

   ldiv_arbiter #(
      .NUM_REQ(NR), .NUMERATOR_WIDTH(W), .DENOMINATOR_WIDTH(W), .QUOTIENT_WIDTH(W),
      .DIV_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .resetb(resetb), .req_valid(req_valid), .req_ready(req_ready),
      .req_numerator(req_numerator), .req_denominator(req_denominator),
      .div_numerator(div_numerator), .div_denominator(div_denominator), .div_valid(div_valid),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_valid_out(div_valid_out),
      .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
      .rsp_div_by_zero(rsp_div_by_zero), .busy(busy), .seq_error(seq_error)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_numerator   = '0;
      req_denominator = '0;
      for (int i = 0; i < NR; i++) begin
         req_numerator[i*W +: W]   = num_a[i];
         req_denominator[i*W +: W] = den_a[i];
      end
   end

   // Behavioural pipelined divider: fixed latency, all-ones quotient on divide by zero.
   logic [LAT-1:0] mv;
   logic [W-1:0]   mq [LAT];
   logic [W-1:0]   mr [LAT];
   always @(posedge clk) begin
      if (!resetb) begin
         mv <= '0;
      end else begin
         mv <= {mv[LAT-2:0], div_valid};
         for (int s = LAT - 1; s > 0; s--) begin
            mq[s] <= mq[s-1];
            mr[s] <= mr[s-1];
         end
         mq[0] <= (div_denominator == '0) ? {W{1'b1}} : div_numerator / div_denominator;
         mr[0] <= (div_denominator == '0) ? div_numerator : div_numerator % div_denominator;
      end
   end
   assign div_valid_out = mv[LAT-1] | force_vo;
   assign div_quotient  = mq[LAT-1];
   assign div_remainder = mr[LAT-1];

   typedef struct {
      int due; int id; int num; int den; int q; int r; bit dbz;
   } pend_t;

   pend_t pq[$];
   int    cyc = 0;
   int    m_ptr = NR - 1;
   bit    m_seq = 1'b0;
   int    n_assert = 0;
   int    n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input bit v, input int n, input int d);
      req_valid[i] = v;
      num_a[i] = W'(n);
      den_a[i] = W'(d);
   endtask

   task automatic step();
      logic [NR-1:0] exp_ready;
      logic [NR-1:0] exp_rsp;
      bit found, have_rsp, exp_dv;
      int gid, idx, cnt;
      pend_t e;
      #1;
      if (resetb) begin
         have_rsp = (pq.size() > 0) && (pq[0].due == cyc);
         exp_ready = '0;
         found = 1'b0;
         gid = 0;
         for (int k = 1; k <= NR; k++) begin
            idx = (m_ptr + k) % NR;
            cnt = 0;
            foreach (pq[j]) if (pq[j].id == idx && pq[j].due > cyc) cnt++;
            if (!found && req_valid[idx] && cnt < MAXO) begin
               found = 1'b1;
               gid = idx;
            end
         end
         if (found) exp_ready[gid] = 1'b1;
         exp_rsp = '0;
         if (have_rsp) exp_rsp[pq[0].id] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_ready));
         chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
         if (have_rsp) begin
            chk("rsp_quotient", 32'(rsp_quotient), pq[0].q);
            chk("rsp_remainder", 32'(rsp_remainder), pq[0].r);
            chk("rsp_div_by_zero", 32'(rsp_div_by_zero), 32'(pq[0].dbz));
         end
         chk("busy", 32'(busy), 32'(pq.size() > 0));
         chk("seq_error", 32'(seq_error), 32'(m_seq));
         exp_dv = 1'b0;
         foreach (pq[j]) begin
            if (pq[j].due == cyc + RSP_LAT - 1) begin
               exp_dv = 1'b1;
               chk("div_numerator", 32'(div_numerator), pq[j].num);
               chk("div_denominator", 32'(div_denominator), pq[j].den);
            end
         end
         chk("div_valid", 32'(div_valid), 32'(exp_dv));
         if (have_rsp) void'(pq.pop_front());
         if (found) begin
            e.due = cyc + RSP_LAT;
            e.id  = gid;
            e.num = int'(num_a[gid]);
            e.den = int'(den_a[gid]);
            e.dbz = (e.den == 0);
            e.q   = e.dbz ? (1 << W) - 1 : e.num / e.den;
            e.r   = e.dbz ? e.num : e.num % e.den;
            pq.push_back(e);
            m_ptr = gid;
         end
         if (force_vo) m_seq = 1'b1;
      end else begin
         pq.delete();
         m_ptr = NR - 1;
         m_seq = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      for (int c = 0; c < n; c++) step();
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         num_a[i] = '0;
         den_a[i] = 10'd1;
      end
      @(negedge clk);
      resetb = 1'b0;
      step();
      step();
      resetb = 1'b1;
      idle(2);

      // Single op on req0: 13/3 -> 4 r1 after RSP_LAT cycles
      set_req(0, 1, 13, 3);
      step();
      req_valid = '0;
      idle(RSP_LAT + 2);

      // All requesters valid every cycle with random operands; req2 carries 100/7
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < NR; i++) set_req(i, 1, $urandom_range(0, 1023), $urandom_range(1, 1023));
         if (c < 4) set_req(2, 1, 100, 7);
         step();
      end
      idle(RSP_LAT + 2);

      // Outstanding limit: req1 alone held valid
      for (int c = 0; c < 35; c++) begin
         set_req(1, 1, $urandom_range(0, 1023), $urandom_range(1, 50));
         step();
      end
      idle(RSP_LAT + 2);

      // Divide by zero on req3
      set_req(3, 1, 25, 0);
      step();
      idle(RSP_LAT + 2);

      // Random traffic, including zero denominators
      for (int c = 0; c < 300; c++) begin
         req_valid = NR'($urandom);
         for (int i = 0; i < NR; i++) begin
            num_a[i] = W'($urandom);
            den_a[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         end
         step();
      end
      idle(RSP_LAT + 2);

      // Reset mid-flight: three ops in the pipe are dropped
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NR; i++) set_req(i, 1, $urandom_range(0, 1023), $urandom_range(1, 1023));
         step();
      end
      req_valid = '0;
      resetb = 1'b0;
      step();
      resetb = 1'b1;
      idle(RSP_LAT + 3);
      for (int i = 0; i < NR; i++) set_req(i, 1, 50 + i, 3);
      step();
      idle(RSP_LAT + 2);

      // Spurious divider valid with an empty tag pipe
      force_vo = 1'b1;
      step();
      force_vo = 1'b0;
      idle(6);
      resetb = 1'b0;
      step();
      resetb = 1'b1;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
